gate_truth_table_sequencer: RTL and testbench
=============================================

// Module: gate_truth_table_sequencer
// PURPOSE
//  Upstream stimulus source and downstream checker for logic_gates_gateflow_model_design.
//  On start it drives a/b through 00,01,10,11 and holds each vector HOLD_CYCLES clocks.
//  In the last hold cycle it compares the seven gate outputs against expected values.
//  Reports per-vector failures and an error count. Synthesizable self-test for the gate block.
// PARAMETERS
//  HOLD_CYCLES  10  clocks each vector is held; legal range >= 2 (first cycle = settle)
//  ERR_W        3   width of err_count; must be >= 3 (max count 4)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      1-cycle request to run the 4-vector sequence
//  a          out  1      stimulus to gate block, registered
//  b          out  1      stimulus to gate block, registered
//  yand       in   1      gate block AND output
//  ynand      in   1      gate block NAND output
//  yor        in   1      gate block OR output
//  ynor       in   1      gate block NOR output
//  ynot       in   1      gate block NOT output (expected ~a)
//  yxor       in   1      gate block XOR output
//  yxnor      in   1      gate block XNOR output
//  busy       out  1      high while sequence running
//  done       out  1      high from end of sequence until next accepted start
//  pass       out  1      valid when done: 1 = no mismatches
//  err_count  out  ERR_W  number of failing vectors in last run
//  fail_mask  out  4      bit i set = vector i ({a,b}=i) mismatched
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE. a=0, b=0, busy=0, done=0, pass=0, err_count=0,
//   fail_mask=0, vec_idx=0, hold_cnt=0. Release is synchronous to the next clk edge.
//  FSM states: IDLE, DRIVE, DONE.
//   IDLE -> DRIVE on start. Set vec_idx=0, {a,b}=00, hold_cnt=0, busy=1.
//    Clear err_count and fail_mask; done=0.
//   DRIVE: hold_cnt increments each clk.
//    When hold_cnt==HOLD_CYCLES-1: compare all 7 inputs against expected({a,b}).
//    On any mismatch: set fail_mask[vec_idx]; err_count+=1.
//    Then, if vec_idx<3: vec_idx+=1, {a,b}=vec_idx+1, hold_cnt=0.
//    Otherwise go to DONE.
//   DONE: busy=0, done=1. pass=(fail_mask==0, including the final vector's result).
//    a and b hold 11. start -> DRIVE with the same clearing as from IDLE.
//  Expected: and=a&b, nand=~(a&b), or=a|b, nor=~(a|b), not=~a, xor=a^b, xnor=~(a^b).
//  Timing: start sampled at edge 0 -> busy=1 after edge 0.
//   done=1 after edge 4*HOLD_CYCLES; busy spans exactly 4*HOLD_CYCLES cycles.
//  start while busy is ignored; no restart or abort.
//  Gate outputs are combinational from registered a/b, so they are settled by the compare cycle.
//   Inputs in hold cycles before the compare cycle are don't-care.
//  err_count cannot exceed 4, so no wrap occurs; ERR_W<3 is illegal.
//  rst_n asserted mid-run: immediate return to reset values. Results of the partial run are lost.
//  X/Z on a gate input at compare time counts as a mismatch (use !==-free logic: compare via ^ and |).
// STRUCTURE
//  Shared package gate_tb_pkg:
//   - state encoding localparams (IDLE=2'd0, DRIVE=2'd1, DONE=2'd2)
//   - NUM_VEC=4
//   - 7-bit output-vector bit positions {and,nand,or,nor,not,xor,xnor}
//  One sub-module, gate_expect: combinational a,b -> 7-bit expected vector.
//   Reused by future checker blocks.
//  The top holds the FSM, hold_cnt ($clog2(HOLD_CYCLES) bits), vec_idx (2 bits) and result registers.
// TESTING
//  1. Correct gate block, HOLD_CYCLES=10, start pulse.
//     -> a,b step 00,01,10,11 every 10 clks; done=1 at cycle 40; pass=1; err_count=0; fail_mask=0000.
//  2. Bench forces yxor=0 always.
//     -> vectors 01,10 fail; fail_mask=0110; err_count=2; pass=0.
//  3. start re-pulsed at cycle 15 while busy.
//     -> ignored; sequence timing identical to test 1.
//  4. rst_n=0 at cycle 25 for 2 clks, then start.
//     -> a=b=0, busy=0, done=0, counts 0 immediately at assertion; the new run completes normally.
//  5. After test 2 finishes, start again with a correct model.
//     -> err_count and fail_mask clear on start; end with pass=1.
//  6. HOLD_CYCLES=2; ynot stuck at 1.
//     -> fail_mask=1100, err_count=2; done at cycle 8.

Source files
------------

// File: rtl/gate_tb_pkg.sv
// -----------------------------------------------------------------------------
// Package : gate_tb_pkg
// Purpose : Shared definitions for the gate-block truth-table sequencer and
//           checker blocks: FSM state encoding, vector count and the bit
//           layout of the 7-bit gate-output vector.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

package gate_tb_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_DRIVE = ST_DRIVE,
        S_DONE  = ST_DONE
    } state_t;

    // Number of {a,b} input combinations walked per run
    localparam int NUM_VEC = 4;

    // Gate-output vector: {and, nand, or, nor, not, xor, xnor}, MSB first
    localparam int GV_W     = 7;
    localparam int BIT_AND  = 6;
    localparam int BIT_NAND = 5;
    localparam int BIT_OR   = 4;
    localparam int BIT_NOR  = 3;
    localparam int BIT_NOT  = 2;
    localparam int BIT_XOR  = 1;
    localparam int BIT_XNOR = 0;

endpackage

`default_nettype wire

// File: rtl/gate_expect.sv
// -----------------------------------------------------------------------------
// Module  : gate_expect
// Purpose : Combinational reference for the gate block. Produces the expected
//           7-bit gate-output vector for a given {a,b}.
// Ports   : i_a, i_b - stimulus bits
//           o_exp    - expected {and,nand,or,nor,not,xor,xnor}
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module gate_expect
    import gate_tb_pkg::*;
(
    input  logic            i_a,
    input  logic            i_b,
    output logic [GV_W-1:0] o_exp
);

    always_comb begin
        o_exp           = '0;
        o_exp[BIT_AND]  = i_a & i_b;
        o_exp[BIT_NAND] = ~(i_a & i_b);
        o_exp[BIT_OR]   = i_a | i_b;
        o_exp[BIT_NOR]  = ~(i_a | i_b);
        o_exp[BIT_NOT]  = ~i_a;
        o_exp[BIT_XOR]  = i_a ^ i_b;
        o_exp[BIT_XNOR] = ~(i_a ^ i_b);
    end

endmodule

`default_nettype wire

// File: rtl/gate_truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// Module  : gate_truth_table_sequencer
// Purpose : Self-test driver/checker for a 7-output logic gate block. On start
//           it walks {a,b} through 00,01,10,11, holding each vector
//           HOLD_CYCLES clocks, and checks all gate outputs in the last hold
//           cycle of each vector.
// Ports   : clk, rst_n            - clock, async active-low reset
//           start                 - one-cycle run request (ignored while busy)
//           a, b                  - registered stimulus to the gate block
//           yand..yxnor           - gate block outputs under test
//           busy                  - run in progress
//           done                  - run finished, results valid
//           pass                  - no vector failed in the last run
//           err_count             - number of failing vectors
//           fail_mask             - bit i set when vector {a,b}=i failed
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module gate_truth_table_sequencer
    import gate_tb_pkg::*;
#(
    parameter int HOLD_CYCLES = 10,
    parameter int ERR_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             yand,
    input  logic             ynand,
    input  logic             yor,
    input  logic             ynor,
    input  logic             ynot,
    input  logic             yxor,
    input  logic             yxnor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_mask
);

    localparam int            HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [1:0]    LAST_VEC  = 2'(NUM_VEC - 1);

    state_t            r_state;
    logic [HC_W-1:0]   r_hold_cnt;
    logic [1:0]        r_vec_idx;
    logic              r_a;
    logic              r_b;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ERR_W-1:0]  r_err_count;
    logic [3:0]        r_fail_mask;

    logic [GV_W-1:0]   w_exp;
    logic [GV_W-1:0]   w_obs;
    logic              w_all_match;
    logic              w_vec_fail;
    logic [3:0]        w_fail_mask_next;
    logic              w_last_hold;
    logic              w_last_vec;

    gate_expect u_expect (
        .i_a   (r_a),
        .i_b   (r_b),
        .o_exp (w_exp)
    );

    always_comb begin
        w_obs           = '0;
        w_obs[BIT_AND]  = yand;
        w_obs[BIT_NAND] = ynand;
        w_obs[BIT_OR]   = yor;
        w_obs[BIT_NOR]  = ynor;
        w_obs[BIT_NOT]  = ynot;
        w_obs[BIT_XOR]  = yxor;
        w_obs[BIT_XNOR] = yxnor;
    end

    assign w_all_match = ~|(w_obs ^ w_exp);

    // Failure is the default and only a definite match clears it, so an
    // unknown value on any gate output is treated as a mismatch.
    always_comb begin
        w_vec_fail = 1'b1;
        if (w_all_match) begin
            w_vec_fail = 1'b0;
        end
    end

    assign w_fail_mask_next = r_fail_mask | (4'(w_vec_fail) << r_vec_idx);
    assign w_last_hold      = (r_hold_cnt == HOLD_LAST);
    assign w_last_vec       = (r_vec_idx == LAST_VEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_hold_cnt  <= '0;
            r_vec_idx   <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_fail_mask <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_DRIVE;
                        r_hold_cnt  <= '0;
                        r_vec_idx   <= '0;
                        r_a         <= 1'b0;
                        r_b         <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err_count <= '0;
                        r_fail_mask <= '0;
                    end
                end
                S_DRIVE: begin
                    if (w_last_hold) begin
                        r_fail_mask <= w_fail_mask_next;
                        r_err_count <= r_err_count + ERR_W'(w_vec_fail);
                        if (!w_last_vec) begin
                            r_vec_idx    <= r_vec_idx + 2'd1;
                            {r_a, r_b}   <= r_vec_idx + 2'd1;
                            r_hold_cnt   <= '0;
                        end else begin
                            // Pass must include the verdict of the final vector,
                            // which is only being folded into the mask this cycle.
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_fail_mask_next == 4'd0);
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HC_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a         = r_a;
    assign b         = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_mask = r_fail_mask;

endmodule

`default_nettype wire

// File: tb/tb_gate_truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// Module  : tb_gate_truth_table_sequencer
// Purpose : Self-checking bench for gate_truth_table_sequencer. Two instances
//           (HOLD_CYCLES=10 and 2) each drive a behavioural gate block with
//           configurable stuck-at / inversion faults per output.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_gate_truth_table_sequencer;

    localparam int HC0 = 10;
    localparam int HC1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rstn;
    logic [1:0]      st;
    logic [1:0][6:0] fen;
    logic [1:0][6:0] fval;
    logic [1:0][6:0] finv;

    wire  [1:0]      oa, ob, obusy, odone, opass;
    wire  [1:0][2:0] oerr;
    wire  [1:0][3:0] omask;
    wire  [6:0]      y0, y1;

    int n_pass  = 0;
    int n_total = 0;

    // Gate truth computed arithmetically: {and,nand,or,nor,not,xor,xnor}
    function automatic logic [6:0] gate_vec(input logic ia, input logic ib);
        int s;
        logic g_and, g_or, g_xor, g_not;
        s     = int'(ia) + int'(ib);
        g_and = (s == 2);
        g_or  = (s >= 1);
        g_xor = (s == 1);
        g_not = (int'(ia) == 0);
        return {g_and, !g_and, g_or, !g_or, g_not, g_xor, !g_xor};
    endfunction

    // Stuck-at takes priority over inversion
    function automatic logic [6:0] faulty(input logic [6:0] good, input logic [6:0] en,
                                          input logic [6:0] val, input logic [6:0] inv);
        return (en & val) | (~en & (good ^ inv));
    endfunction

    // Vector v fails when the faulted gate block differs from a good one
    function automatic logic [3:0] predict(input logic [6:0] en, input logic [6:0] val,
                                           input logic [6:0] inv);
        logic [3:0] m;
        logic [6:0] g;
        m = 4'd0;
        for (int v = 0; v < 4; v++) begin
            g = gate_vec(v[1], v[0]);
            if (faulty(g, en, val, inv) != g) m[v] = 1'b1;
        end
        return m;
    endfunction

    assign y0 = faulty(gate_vec(oa[0], ob[0]), fen[0], fval[0], finv[0]);
    assign y1 = faulty(gate_vec(oa[1], ob[1]), fen[1], fval[1], finv[1]);

    gate_truth_table_sequencer #(.HOLD_CYCLES(HC0), .ERR_W(3)) u_dut0 (
        .clk       (clk),
        .rst_n     (rstn[0]),
        .start     (st[0]),
        .a         (oa[0]),
        .b         (ob[0]),
        .yand      (y0[6]),
        .ynand     (y0[5]),
        .yor       (y0[4]),
        .ynor      (y0[3]),
        .ynot      (y0[2]),
        .yxor      (y0[1]),
        .yxnor     (y0[0]),
        .busy      (obusy[0]),
        .done      (odone[0]),
        .pass      (opass[0]),
        .err_count (oerr[0]),
        .fail_mask (omask[0])
    );

    gate_truth_table_sequencer #(.HOLD_CYCLES(HC1), .ERR_W(3)) u_dut1 (
        .clk       (clk),
        .rst_n     (rstn[1]),
        .start     (st[1]),
        .a         (oa[1]),
        .b         (ob[1]),
        .yand      (y1[6]),
        .ynand     (y1[5]),
        .yor       (y1[4]),
        .ynor      (y1[3]),
        .ynot      (y1[2]),
        .yxor      (y1[1]),
        .yxnor     (y1[0]),
        .busy      (obusy[1]),
        .done      (odone[1]),
        .pass      (opass[1]),
        .err_count (oerr[1]),
        .fail_mask (omask[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One complete run on instance sel, checked cycle by cycle
    task automatic run(input int sel, input string name, input logic [6:0] en,
                       input logic [6:0] val, input logic [6:0] inv,
                       input int repulse, input logic [3:0] exp_mask);
        int hc, bad, first_bad, q;
        hc = (sel == 0) ? HC0 : HC1;
        fen[sel] = en; fval[sel] = val; finv[sel] = inv;
        @(negedge clk);
        st[sel] = 1'b1;
        @(posedge clk);
        #1 st[sel] = 1'b0;
        chk({name, " start"}, 32'({obusy[sel], odone[sel], opass[sel], oerr[sel], omask[sel]}),
            32'({1'b1, 1'b0, 1'b0, 3'd0, 4'd0}));
        bad = 0;
        first_bad = -1;
        for (int k = 1; k <= 4 * hc; k++) begin
            st[sel] = (k == repulse);
            @(posedge clk);
            #1;
            q = (k < 4 * hc) ? (k / hc) : 3;
            if ({oa[sel], ob[sel]} !== 2'(q) || obusy[sel] !== (k < 4 * hc) ||
                odone[sel] !== (k == 4 * hc)) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        st[sel] = 1'b0;
        chk({name, " timing (first bad cycle)"}, 32'(first_bad), 32'hFFFF_FFFF);
        chk({name, " fail_mask"}, 32'(omask[sel]), 32'(exp_mask));
        chk({name, " err_count"}, 32'(oerr[sel]), 32'($countones(exp_mask)));
        chk({name, " pass"}, 32'(opass[sel]), 32'(exp_mask == 4'd0));
        repeat (3) @(posedge clk);
        #1 chk({name, " done hold"}, 32'({obusy[sel], odone[sel], oa[sel], ob[sel]}), 32'(4'b0111));
    endtask

    typedef struct {
        string      name;
        logic [6:0] en;
        logic [6:0] val;
        logic [6:0] inv;
        int         repulse;
        logic [3:0] exp_mask;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [6:0] ren, rval, rinv;
        int rsel;

        tbl[0] = '{"t1 good",            7'b0000000, 7'b0000000, 7'b0000000,  0, 4'b0000};
        tbl[1] = '{"t3 restart ignored", 7'b0000000, 7'b0000000, 7'b0000000, 15, 4'b0000};
        tbl[2] = '{"t2 xor stuck0",      7'b0000010, 7'b0000000, 7'b0000000,  0, 4'b0110};
        tbl[3] = '{"t5 good after fail", 7'b0000000, 7'b0000000, 7'b0000000,  0, 4'b0000};
        tbl[4] = '{"and stuck1",         7'b1000000, 7'b1000000, 7'b0000000,  0, 4'b0111};
        tbl[5] = '{"not inverted",       7'b0000000, 7'b0000000, 7'b0000100,  0, 4'b1111};
        tbl[6] = '{"nor stuck0",         7'b0001000, 7'b0000000, 7'b0000000,  0, 4'b0001};

        rstn = 2'b00; st = 2'b00; fen = '0; fval = '0; finv = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++)
            chk($sformatf("reset state dut%0d", s),
                32'({oa[s], ob[s], obusy[s], odone[s], opass[s], oerr[s], omask[s]}), 32'd0);
        @(negedge clk) rstn = 2'b11;

        for (int i = 0; i < 7; i++)
            run(0, tbl[i].name, tbl[i].en, tbl[i].val, tbl[i].inv, tbl[i].repulse, tbl[i].exp_mask);

        // Asynchronous reset in the middle of a run, then a clean rerun
        fen[0] = '0; fval[0] = '0; finv[0] = '0;
        @(negedge clk) st[0] = 1'b1;
        @(posedge clk);
        #1 st[0] = 1'b0;
        repeat (25) @(posedge clk);
        #1 chk("t4 busy before reset", 32'({obusy[0], oa[0], ob[0]}), 32'(3'b110));
        #1 rstn[0] = 1'b0;
        #1 chk("t4 async reset values",
               32'({oa[0], ob[0], obusy[0], odone[0], opass[0], oerr[0], omask[0]}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rstn[0] = 1'b1;
        run(0, "t4 run after reset", 7'd0, 7'd0, 7'd0, 0, 4'b0000);

        run(1, "t6 hc2 not stuck1", 7'b0000100, 7'b0000100, 7'b0000000, 0, 4'b1100);

        // Random fault patterns against the reference model
        for (int r = 0; r < 8; r++) begin
            rsel = int'($urandom_range(0, 1));
            ren  = 7'($urandom) & 7'($urandom);
            rval = 7'($urandom);
            rinv = 7'($urandom) & 7'($urandom) & 7'($urandom);
            run(rsel, $sformatf("rand%0d dut%0d", r, rsel), ren, rval, rinv, 0,
                predict(ren, rval, rinv));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
